// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display path.
package seg_pkg;

    localparam int unsigned SEG_DIGITS = 8;
    localparam logic [SEG_DIGITS-1:0] AN_ALL_OFF = 8'hFF;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } slot_state_t;

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running prescaler: cnt_o counts 0..DIV-1, tick_c marks the wrap cycle.
module seg_tick_gen #(
    parameter  int unsigned DIV = 100000,
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt_o,
    output logic          tick_c
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick_c = (cnt_q == CNT_LAST);
        cnt_d  = tick_c ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed digit scanner: one active-low anode per slot, with a
// dark lead-in at each slot start and frame-aligned input snapshots.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = SEG_DIGITS,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   en_mask_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [3:0]              digit_o,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    DP,
    output logic                    frame_o
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VW = 4 * NUM_DIGITS;

    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic          NO_BLANK   = (BLANK_CYCLES == 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    if (BLANK_CYCLES >= TICK_DIV) begin : g_bad_blank
        $error("seg_scan_mux: BLANK_CYCLES must be less than TICK_DIV");
    end
    if (NUM_DIGITS < 2) begin : g_bad_digits
        $error("seg_scan_mux: NUM_DIGITS must be at least 2");
    end

    logic [CW-1:0] cnt;
    logic          tick;

    seg_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .cnt_o  (cnt),
        .tick_c (tick)
    );

    slot_state_t           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         val_q, val_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [NUM_DIGITS-1:0] dps_q, dps_d;
    nibble_t               digit_q, digit_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  dp_pin_q, dp_pin_d;
    logic                  frame_q, frame_d;
    logic                  frame_wrap;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        val_d    = val_q;
        mask_d   = mask_q;
        dps_d    = dps_q;
        an_d     = AN_OFF;
        dp_pin_d = 1'b1;

        frame_wrap = tick && (idx_q == IDX_LAST);

        // Tick and frame wrap coincide: snapshot, index reset and blank entry land together.
        if (tick) begin
            idx_d   = frame_wrap ? '0 : idx_q + IW'(1);
            state_d = NO_BLANK ? ON : BLANK;
        end else if (state_q == BLANK && (NO_BLANK || cnt == BLANK_LAST)) begin
            state_d = ON;
        end

        if (frame_wrap) begin
            val_d  = value_i;
            mask_d = en_mask_i;
            dps_d  = dp_i;
        end

        // Nibble follows idx in both states so the decoder settles during the blank lead-in.
        digit_d = val_q[{idx_q, 2'b00} +: 4];
        if (state_q == ON && mask_q[idx_q]) begin
            an_d     = ~(AN_ONE << idx_q);
            dp_pin_d = ~dps_q[idx_q];
        end
        frame_d = frame_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BLANK;
            idx_q    <= '0;
            val_q    <= '0;
            mask_q   <= '0;
            dps_q    <= '0;
            digit_q  <= '0;
            an_q     <= AN_OFF;
            dp_pin_q <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            val_q    <= val_d;
            mask_q   <= mask_d;
            dps_q    <= dps_d;
            digit_q  <= digit_d;
            an_q     <= an_d;
            dp_pin_q <= dp_pin_d;
            frame_q  <= frame_d;
        end
    end

    assign digit_o = digit_q;
    assign AN      = an_q;
    assign DP      = dp_pin_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with a short prescaler (8 cycles/slot, 2 blank).
module tb_seg_scan_mux;

    localparam int unsigned ND  = 8;
    localparam int unsigned DIV = 8;
    localparam int unsigned BLK = 2;
    localparam logic [31:0] VAL_A = 32'h8765_4321;
    localparam logic [31:0] VAL_B = 32'h0A1B_2C3D;

    logic          clk;
    logic          rst;
    logic [31:0]   value_i;
    logic [7:0]    en_mask_i;
    logic [7:0]    dp_i;
    logic [3:0]    digit_o;
    logic [7:0]    AN;
    logic          DP;
    logic          frame_o;

    seg_scan_mux #(
        .NUM_DIGITS   (ND),
        .TICK_DIV     (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value_i   (value_i),
        .en_mask_i (en_mask_i),
        .dp_i      (dp_i),
        .digit_o   (digit_o),
        .AN        (AN),
        .DP        (DP),
        .frame_o   (frame_o)
    );

    typedef struct {
        int         tag;
        int         slot;
        logic [7:0] an;
        logic [3:0] dig;
        logic       dp;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int frame_cnt = 0;
    int mon_n     = 0;
    bit in_frame  = 0;
    bit post_rst  = 1;
    bit prev_valid = 0;
    logic [7:0] prev_an;
    logic [3:0] prev_digit;
    logic       prev_frame;
    int low_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected per-slot response for one frame, derived from the inputs snapshotted for it.
    task automatic plan_frame(input int tag, input logic [31:0] v, input logic [7:0] m,
                              input logic [7:0] d);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.tag  = tag;
            e.slot = k;
            e.dig  = v[4*k +: 4];
            e.an   = m[k] ? ~(8'h01 << k) : 8'hFF;
            e.dp   = ~(d[k] & m[k]);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_pos(input int f, input int n);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (frame_cnt == f && mon_n == n && in_frame) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_pos: timeout waiting for frame %0d pos %0d (now frame %0d)", f, n, frame_cnt);
    endtask

    // Monitor: continuous invariants plus scoreboard pops at mid-slot.
    always @(negedge clk) begin
        if (rst) begin
            in_frame   = 0;
            post_rst   = 1;
            low_cnt    = 0;
            prev_valid = 0;
        end else begin
            check("one_hot_an", 32'($countones(~AN) <= 1), 32'd1);
            if (prev_valid && prev_an != 8'hFF && AN != 8'hFF)
                check("digit_stable", 32'(digit_o), 32'(prev_digit));
            if (prev_valid && prev_frame)
                check("frame_width", 32'(frame_o), 32'd0);
            if (AN != 8'hFF) begin
                low_cnt++;
            end else begin
                if (low_cnt != 0) check("an_low_len", 32'(low_cnt), 32'd6);
                low_cnt = 0;
            end
            if (post_rst && !frame_o) check("post_rst_dark", 32'(AN), 32'hFF);

            if (frame_o) begin
                if (in_frame) check("frame_period", 32'(mon_n + 1), 32'd64);
                frame_cnt++;
                mon_n    = 0;
                in_frame = 1;
                post_rst = 0;
            end else if (in_frame) begin
                mon_n++;
            end

            if (in_frame && mon_n < 64 && (mon_n % 8) == 2) begin
                check("blank_an", 32'(AN), 32'hFF);
                check("blank_dp", 32'(DP), 32'd1);
            end
            if (in_frame && mon_n < 64 && (mon_n % 8) == 5) begin
                while (sb_q.size() > 0 && sb_q[0].tag < frame_cnt) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_missed: frame %0d slot %0d never observed", sb_q[0].tag, sb_q[0].slot);
                    void'(sb_q.pop_front());
                end
                if (sb_q.size() > 0 && sb_q[0].tag == frame_cnt && sb_q[0].slot == mon_n / 8) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("slot_an f%0d s%0d", e.tag, e.slot), 32'(AN), 32'(e.an));
                    check($sformatf("slot_digit f%0d s%0d", e.tag, e.slot), 32'(digit_o), 32'(e.dig));
                    check($sformatf("slot_dp f%0d s%0d", e.tag, e.slot), 32'(DP), 32'(e.dp));
                end
            end

            prev_valid = 1;
            prev_an    = AN;
            prev_digit = digit_o;
            prev_frame = frame_o;
        end
    end

    initial begin
        int i;
        int j;
        rst       = 1'b1;
        value_i   = VAL_A;
        en_mask_i = 8'hFF;
        dp_i      = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        check("rst_an", 32'(AN), 32'hFF);
        check("rst_dp", 32'(DP), 32'd1);
        check("rst_digit", 32'(digit_o), 32'd0);
        check("rst_frame", 32'(frame_o), 32'd0);
        rst = 1'b0;

        // Frames 1-2 show A; A is replaced by B while frame 2 is on digit 3.
        plan_frame(1, VAL_A, 8'hFF, 8'h00);
        plan_frame(2, VAL_A, 8'hFF, 8'h00);
        wait_pos(2, 28);
        check("idx3_an", 32'(AN), 32'hF7);
        value_i = VAL_B;
        plan_frame(3, VAL_B, 8'hFF, 8'h00);

        wait_pos(3, 1);
        en_mask_i = 8'b0000_0101;
        plan_frame(4, VAL_B, 8'b0000_0101, 8'h00);

        wait_pos(4, 1);
        en_mask_i = 8'hFF;
        dp_i      = 8'h80;
        plan_frame(5, VAL_B, 8'hFF, 8'h80);

        // Reset in the middle of digit 2's lit window.
        wait_pos(6, 21);
        check("pre_rst_an", 32'(AN), 32'hFB);
        #1 rst = 1'b1;
        #1;
        check("midrst_an", 32'(AN), 32'hFF);
        check("midrst_dp", 32'(DP), 32'd1);
        check("midrst_digit", 32'(digit_o), 32'd0);
        check("midrst_frame", 32'(frame_o), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        plan_frame(7, VAL_B, 8'hFF, 8'h80);

        for (i = 1; i <= 200; i++) begin
            @(negedge clk);
            #1;
            if (frame_o) break;
        end
        check("first_frame_delay", 32'(i), 32'd64);
        for (j = 1; j <= 20; j++) begin
            @(negedge clk);
            #1;
            if (AN != 8'hFF) break;
        end
        check("first_an_delay", 32'(j), 32'd3);
        check("first_an_value", 32'(AN), 32'hFE);

        wait_pos(8, 1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
